// File: rtl/zorro_master_cycle.sv
// ---------------------------------------------------------------------------
// zorro_master_cycle
// Bus-master cycle engine for a Zorro-style expansion bus. Takes one DMA
// request at a time, runs the address-setup / strobe / wait / release
// sequence on the bus, and ends every accepted request with a one-cycle ack
// (err qualifies it: bus error or DTACK timeout).
//
// Parameters
//   ADDR_SETUP  cycles ADDR is held before FCS_n falls (1-15)
//   TIMEOUT     max WAIT cycles before the cycle is ended with err (1-1023)
//
// Ports
//   CLK, RESET            clock, asynchronous active-high reset
//   bus_granted           arbiter grant, checked only when leaving IDLE
//   req, req_*            DMA request: address, direction, write data, BEs
//   ack, err, rdata       completion pulse, error flag, read data
//   ADDR, FCS_n, READ     bus address, full cycle strobe, direction
//   DS_n, DOE, DOUT       data strobes, data output enable, write data
//   DIN                   read data from the bus
//   DTACK_n, BERR_n       asynchronous slave acknowledge / bus error
// ---------------------------------------------------------------------------
module zorro_master_cycle #(
   parameter int unsigned ADDR_SETUP = 1,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        bus_granted,
   input  logic        req,
   input  logic [31:0] req_addr,
   input  logic        req_write,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        ack,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] ADDR,
   output logic        FCS_n,
   output logic        READ,
   output logic [3:0]  DS_n,
   output logic        DOE,
   output logic [31:0] DOUT,
   input  logic [31:0] DIN,
   input  logic        DTACK_n,
   input  logic        BERR_n
);

   localparam int unsigned CNT_W = 10;
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ADDR_SETUP - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_WAIT,
      ST_RELEASE,
      ST_RECOVER
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_write, w_write_nxt;
   logic [31:0]       r_wdata, w_wdata_nxt;
   logic [3:0]        r_be, w_be_nxt;

   logic              r_ack, w_ack_nxt;
   logic              r_err, w_err_nxt;
   logic [31:0]       r_rdata, w_rdata_nxt;
   logic [31:0]       r_addr, w_addr_nxt;
   logic              r_fcs_n, w_fcs_n_nxt;
   logic              r_read, w_read_nxt;
   logic [3:0]        r_ds_n, w_ds_n_nxt;
   logic              r_doe, w_doe_nxt;
   logic [31:0]       r_dout, w_dout_nxt;

   logic [1:0]        r_dtack_sync;
   logic [1:0]        r_berr_sync;
   logic              w_dtack;
   logic              w_berr;

   // Two-flop synchronizers; stored active-high so reset value 0 means idle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_dtack_sync <= 2'b00;
         r_berr_sync  <= 2'b00;
      end else begin
         r_dtack_sync <= {r_dtack_sync[0], ~DTACK_n};
         r_berr_sync  <= {r_berr_sync[0], ~BERR_n};
      end
   end

   assign w_dtack = r_dtack_sync[1];
   assign w_berr  = r_berr_sync[1];

   // State and registered-output update.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
         r_be    <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         r_addr  <= '0;
         r_fcs_n <= 1'b1;
         r_read  <= 1'b1;
         r_ds_n  <= 4'hF;
         r_doe   <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_write <= w_write_nxt;
         r_wdata <= w_wdata_nxt;
         r_be    <= w_be_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_rdata <= w_rdata_nxt;
         r_addr  <= w_addr_nxt;
         r_fcs_n <= w_fcs_n_nxt;
         r_read  <= w_read_nxt;
         r_ds_n  <= w_ds_n_nxt;
         r_doe   <= w_doe_nxt;
         r_dout  <= w_dout_nxt;
      end
   end

   // Next state and next output values; each bus action is registered on the
   // transition into the state that owns it, so outputs line up with state.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_write_nxt = r_write;
      w_wdata_nxt = r_wdata;
      w_be_nxt    = r_be;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = r_rdata;
      w_addr_nxt  = r_addr;
      w_fcs_n_nxt = r_fcs_n;
      w_read_nxt  = r_read;
      w_ds_n_nxt  = r_ds_n;
      w_doe_nxt   = r_doe;
      w_dout_nxt  = r_dout;

      case (r_state)
         ST_IDLE: begin
            if (req && bus_granted) begin
               w_addr_nxt  = req_addr;
               w_read_nxt  = ~req_write;
               w_write_nxt = req_write;
               w_wdata_nxt = req_wdata;
               w_be_nxt    = req_be;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (r_cnt == SETUP_LAST) begin
               w_fcs_n_nxt = 1'b0;
               w_state_nxt = ST_STROBE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         ST_STROBE: begin
            w_ds_n_nxt = ~r_be;
            if (r_write) begin
               w_doe_nxt  = 1'b1;
               w_dout_nxt = r_wdata;
            end
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT;
         end

         ST_WAIT: begin
            // BERR has priority over DTACK; timeout is the last resort.
            if (w_berr || w_dtack || (r_cnt == TO_LAST)) begin
               w_fcs_n_nxt = 1'b1;
               w_ds_n_nxt  = 4'hF;
               w_doe_nxt   = 1'b0;
               w_ack_nxt   = 1'b1;
               w_err_nxt   = w_berr || !w_dtack;
               if (!w_berr && w_dtack && !r_write) begin
                  w_rdata_nxt = DIN;
               end
               w_state_nxt = ST_RELEASE;
            end else if (r_cnt != CNT_MAX) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         ST_RELEASE: begin
            w_state_nxt = ST_RECOVER;
         end

         ST_RECOVER: begin
            // Wait for the slave to withdraw before the next cycle may start.
            if (!w_dtack && !w_berr) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign ack   = r_ack;
   assign err   = r_err;
   assign rdata = r_rdata;
   assign ADDR  = r_addr;
   assign FCS_n = r_fcs_n;
   assign READ  = r_read;
   assign DS_n  = r_ds_n;
   assign DOE   = r_doe;
   assign DOUT  = r_dout;

endmodule
